serial_slice_adder: RTL and testbench
=====================================

// Module: serial_slice_adder
// PURPOSE
//  Parametrised multi-cycle binary adder: WIDTH-bit operands summed SLICE bits per clock,
//  LSB slice first, carry held in a register between slices (time-multiplexed 74LS83 cascade).
//  Sits in the digital-base IP set as the wide-operand adder for datapath labs.
//  Adds start/busy/done handshake, registered result and signed overflow flag.
// PARAMETERS
//  WIDTH  16  operand/result width; must be an integer multiple of SLICE
//  SLICE  4   bits added per clock; NSLICE = WIDTH/SLICE cycles per operation
// PORTS
//  clk    in   1      clock, all state on rising edge
//  rst    in   1      synchronous, active-high reset
//  start  in   1      request; sampled only when busy=0
//  A      in   WIDTH  operand A, captured on accepted start
//  B      in   WIDTH  operand B, captured on accepted start
//  C0     in   1      carry-in, captured on accepted start
//  busy   out  1      high while slices are being added (RUN)
//  done   out  1      one-cycle pulse: Sum/Cout/OVF valid
//  Sum    out  WIDTH  result, registered, held until next accepted start
//  Cout   out  1      carry out of MSB
//  OVF    out  1      signed overflow = carry into MSB XOR Cout
// BEHAVIOUR
//  - Clock clk, reset rst: one clock, reset synchronous, active-high.
//  - Reset: state IDLE; busy=0, done=0, Sum=0, Cout=0, OVF=0; slice counter and carry reg 0.
//  - FSM: IDLE -(start)-> RUN; RUN -(counter==NSLICE-1)-> DONE; DONE -(start)-> RUN,
//    else -> IDLE. busy=1 only in RUN; done=1 only in DONE.
//  - Accept: start=1 and busy=0 at an edge latches A, B, C0; counter<=0; Sum/Cout/OVF cleared.
//  - RUN edge k (k=0..NSLICE-1): {c,Sum[k*SLICE+:SLICE]} <= A_slice + B_slice + carry;
//    carry seeded with C0 for k=0. Cout and OVF written on the final slice edge.
//  - Latency: start high in cycle 0 -> busy cycles 1..NSLICE -> done high in cycle NSLICE+1.
//  - start while busy=1: ignored, no effect on operands or result.
//  - start in DONE: accepted; done still 1 that cycle, RUN entered next edge.
//  - Operand inputs may change after acceptance without effect (latched copies used).
//  - NSLICE=1 legal: single RUN cycle. Arithmetic modulo 2^WIDTH; Cout is bit WIDTH.
//  - Reset mid-operation: aborts immediately, all outputs to reset values, no done pulse.
// CONFIGURATION
//  SUB_MODE_EN defined: extra input port SUB (1 bit) captured at accept; SUB=1 computes
//   A - B as A + ~B + 1 (C0 ignored); Cout=1 means no borrow; OVF is signed-subtract overflow.
//   SUB=0 behaves exactly as add mode.
//  SUB_MODE_EN undefined: no SUB port; add-only, identical timing.
// TESTING (WIDTH=16, SLICE=4 unless stated)
//  1 A=0x1234 B=0x4321 C0=0 start@0 -> busy cycles 1-4, done@5, Sum=0x5555 Cout=0 OVF=0
//  2 A=0xFFFF B=0x0001 C0=0 -> Sum=0x0000 Cout=1 OVF=0; A=0x7FFF B=0x0001 -> Sum=0x8000 Cout=0 OVF=1
//  3 A=0x0FFF B=0x0000 C0=1 -> Sum=0x1000 (carry across 3 slice boundaries) Cout=0
//  4 start pulsed in cycles 2,3 of an op with new operands -> ignored, original result at done@5;
//    start held high in done cycle -> back-to-back op, second done@10
//  5 rst=1 in cycle 2 of op -> next cycle busy=0 done=0 Sum=0; fresh start then completes normally
//  6 SUB_MODE_EN, SUB=1: 0x0005-0x0007 -> Sum=0xFFFE Cout=0; 0x0007-0x0005 -> Sum=0x0002 Cout=1;
//    WIDTH=8 SLICE=8: 0x80+0x80 -> done@2 Sum=0x00 Cout=1 OVF=1

Source files
------------

// File: rtl/serial_slice_adder.sv
// serial_slice_adder: WIDTH-bit adder that works SLICE bits per clock, LSB
// slice first, carrying between slices in a register. A start/busy/done
// handshake frames each operation. Sum, Cout and OVF are registered and held
// until the next accepted start.
// Optional feature macro: SUB_MODE_EN adds a SUB input. When SUB=1 the block
// computes A - B as A + ~B + 1.
module serial_slice_adder #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             C0,
`ifdef SUB_MODE_EN
   input  logic             SUB,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             OVF
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] b_in;
   logic             c_in;
   logic             accept;
   int               idx;
   logic [SLICE-1:0] a_sl;
   logic [SLICE-1:0] b_sl;
   logic [SLICE:0]   s_sl;
   logic             msb_cin;

   assign busy   = (state == S_RUN);
   assign done   = (state == S_DONE);
   // A start is honoured in IDLE and in DONE, and it is never honoured while slices are running.
   assign accept = start && (state != S_RUN);

   // Condition the operands at accept time. Subtraction is folded into the stored B and the carry seed, so the run phase only ever adds.
   always_comb begin
      b_in = B;
      c_in = C0;
`ifdef SUB_MODE_EN
      if (SUB) begin
         b_in = ~B;
         c_in = 1'b1;
      end
`endif
   end

   // Add one slice. The carry into the MSB is recovered from the top sum bit so that OVF can be formed.
   always_comb begin
      idx     = int'(cnt) * SLICE;
      a_sl    = a_r[idx +: SLICE];
      b_sl    = b_r[idx +: SLICE];
      s_sl    = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry};
      msb_cin = a_sl[SLICE-1] ^ b_sl[SLICE-1] ^ s_sl[SLICE-1];
   end

   // Control FSM and datapath registers. Reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
         carry <= 1'b0;
         a_r   <= '0;
         b_r   <= '0;
         Sum   <= '0;
         Cout  <= 1'b0;
         OVF   <= 1'b0;
      end else if (accept) begin
         state <= S_RUN;
         cnt   <= '0;
         carry <= c_in;
         a_r   <= A;
         b_r   <= b_in;
         Sum   <= '0;
         Cout  <= 1'b0;
         OVF   <= 1'b0;
      end else begin
         case (state)
            S_RUN: begin
               Sum[idx +: SLICE] <= s_sl[SLICE-1:0];
               carry             <= s_sl[SLICE];
               if (cnt == LAST) begin
                  Cout  <= s_sl[SLICE];
                  OVF   <= s_sl[SLICE] ^ msb_cin;
                  state <= S_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_slice_adder.sv
// tb_serial_slice_adder: table vectors, hand-written multi-cycle sequences and
// random operations. Results are checked against an arithmetic reference model.
module tb_serial_slice_adder;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, C0, sub_drv;
   logic [15:0] A, B;
   logic        busy, done, Cout, OVF;
   logic [15:0] Sum;

   logic        start8, C08, sub8;
   logic [7:0]  A8, B8;
   logic        busy8, done8, Cout8, OVF8;
   logic [7:0]  Sum8;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_slice_adder #(.WIDTH(16), .SLICE(4)) dut (
      .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .C0(C0),
`ifdef SUB_MODE_EN
      .SUB(sub_drv),
`endif
      .busy(busy), .done(done), .Sum(Sum), .Cout(Cout), .OVF(OVF));

   serial_slice_adder #(.WIDTH(8), .SLICE(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .A(A8), .B(B8), .C0(C08),
`ifdef SUB_MODE_EN
      .SUB(sub8),
`endif
      .busy(busy8), .done(done8), .Sum(Sum8), .Cout(Cout8), .OVF(OVF8));

   typedef struct {
      logic [15:0] a, b;
      logic        c0, sub;
      logic [15:0] sum;
      logic        cout, ovf;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Reference model: ordinary w-bit two's-complement arithmetic. Returns {ovf, cout, sum}.
   function automatic logic [17:0] model(input int w, input logic [15:0] a, b,
                                         input logic c0, sub);
      logic [31:0] mask, bb, full;
      logic [15:0] s;
      logic        co, ov;
      mask = (32'd1 << w) - 32'd1;
      bb   = sub ? (~{16'h0, b}) & mask : {16'h0, b};
      full = {16'h0, a} + bb + {31'h0, (sub ? 1'b1 : c0)};
      s    = full[15:0];
      co   = full[w];
      ov   = (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
      return {ov, co, s};
   endfunction

   // Start an operation in the current cycle and return the outputs seen in the done cycle.
   // The task returns at the done cycle, so a following call starts back-to-back.
   task automatic run_op(input logic [15:0] a, b, input logic c0, sub,
                         output logic [15:0] s, output logic co, ov);
      logic ok;
      A = a; B = b; C0 = c0; sub_drv = sub; start = 1'b1;
      ok = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (busy !== 1'b1 || done !== 1'b0) ok = 1'b0;
         if (k == 1) begin
            chk("sum_cleared_on_accept", {16'h0, Sum}, 32'h0);
            start = 1'b0; A = 16'($urandom); B = 16'($urandom); C0 = 1'($urandom);
            sub_drv = 1'($urandom);
         end
      end
      @(negedge clk);
      chk("busy_window", {31'h0, ok}, 32'h1);
      chk("done_pulse", {30'h0, busy, done}, 32'h1);
      s = Sum; co = Cout; ov = OVF;
   endtask

   initial begin
      logic [15:0] s;
      logic        co, ov, ok, sb;
      logic [17:0] exp;
      logic [15:0] ra, rb;
      logic        rc;
      int          gap;

      rst = 1'b1; start = 1'b0; A = '0; B = '0; C0 = 1'b0; sub_drv = 1'b0;
      start8 = 1'b0; A8 = '0; B8 = '0; C08 = 1'b0; sub8 = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {11'h0, busy, done, Sum, Cout, OVF}, 32'h0);
      chk("reset_outputs8", {19'h0, busy8, done8, Sum8, Cout8, OVF8}, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // Directed vectors with hand-computed expected results.
      vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0});
      vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
      vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1});
      vecs.push_back('{16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0});
      vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1});
      vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0});
`ifdef SUB_MODE_EN
      vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0});
      vecs.push_back('{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0});
      vecs.push_back('{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1});
`endif
      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].c0, vecs[i].sub, s, co, ov);
         chk($sformatf("vec%0d_sum", i), {16'h0, s}, {16'h0, vecs[i].sum});
         chk($sformatf("vec%0d_cout_ovf", i), {30'h0, co, ov}, {30'h0, vecs[i].cout, vecs[i].ovf});
         @(negedge clk);
         chk("done_one_cycle", {31'h0, done}, 32'h0);
      end

      // A start while busy is ignored. A start held in the done cycle launches the next operation.
      A = 16'h1111; B = 16'h2222; C0 = 1'b0; sub_drv = 1'b0; start = 1'b1;
      @(negedge clk); start = 1'b0; A = 16'hFFFF; B = 16'hFFFF;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b1;
      @(negedge clk); chk("busy_c4", {31'h0, busy}, 32'h1); start = 1'b0;
      @(negedge clk);
      chk("ignored_start_done5", {30'h0, busy, done}, 32'h1);
      chk("ignored_start_sum", {16'h0, Sum}, 32'h3333);
      A = 16'h0101; B = 16'h0202; C0 = 1'b1; start = 1'b1;
      ok = 1'b1;
      for (int c = 6; c <= 9; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (busy !== 1'b1 || done !== 1'b0) ok = 1'b0;
      end
      chk("b2b_busy_6_9", {31'h0, ok}, 32'h1);
      @(negedge clk);
      chk("b2b_done10", {30'h0, busy, done}, 32'h1);
      chk("b2b_sum", {15'h0, Sum, Cout}, {15'h0, 16'h0304, 1'b0});
      @(negedge clk);

      // A reset in the middle of an operation aborts it, and no done pulse follows.
      A = 16'h1234; B = 16'h4321; C0 = 1'b0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      chk("abort_outputs", {11'h0, busy, done, Sum, Cout, OVF}, 32'h0);
      rst = 1'b0;
      ok = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (busy !== 1'b0 || done !== 1'b0) ok = 1'b0;
      end
      chk("abort_no_done", {31'h0, ok}, 32'h1);
      exp = model(16, 16'h0FF0, 16'h0F0F, 1'b1, 1'b0);
      run_op(16'h0FF0, 16'h0F0F, 1'b1, 1'b0, s, co, ov);
      chk("after_abort_result", {14'h0, ov, co, s}, {14'h0, exp});
      @(negedge clk);

      // Single-slice instance: one busy cycle, and done arrives in cycle 2.
      A8 = 8'h80; B8 = 8'h80; C08 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      chk("n1_busy1", {30'h0, busy8, done8}, 32'h2);
      start8 = 1'b0;
      @(negedge clk);
      chk("n1_done2", {30'h0, busy8, done8}, 32'h1);
      chk("n1_result", {22'h0, Sum8, Cout8, OVF8}, {22'h0, 8'h00, 1'b1, 1'b1});
      for (int i = 0; i < 10; i++) begin
         ra = 16'($urandom_range(255)); rb = 16'($urandom_range(255)); rc = 1'($urandom);
`ifdef SUB_MODE_EN
         sb = 1'($urandom);
`else
         sb = 1'b0;
`endif
         exp = model(8, ra, rb, rc, sb);
         A8 = ra[7:0]; B8 = rb[7:0]; C08 = rc; sub8 = sb; start8 = 1'b1;
         @(negedge clk); start8 = 1'b0;
         @(negedge clk);
         chk("n1_rand", {21'h0, done8, OVF8, Cout8, Sum8}, {21'h0, 1'b1, exp[17], exp[16], exp[7:0]});
      end

      // Random operations with random gaps, including back-to-back starts.
      for (int i = 0; i < 60; i++) begin
         ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
         if (i % 8 == 0) ra = 16'h7FFF;
         if (i % 8 == 1) rb = 16'hFFFF;
`ifdef SUB_MODE_EN
         sb = 1'($urandom);
`else
         sb = 1'b0;
`endif
         exp = model(16, ra, rb, rc, sb);
         run_op(ra, rb, rc, sb, s, co, ov);
         chk($sformatf("rand%0d", i), {14'h0, ov, co, s}, {14'h0, exp});
         gap = int'($urandom_range(2));
         if (gap > 0) begin
            @(negedge clk);
            chk("rand_done_one_cycle", {31'h0, done}, 32'h0);
            repeat (gap - 1) @(negedge clk);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
